// File: rtl/d_mem_lsu_if.sv
// Request/response bundle between the d_mem stage and the load/store unit.
// The unit sits on the slave side. The stage, or a bench, drives the master side.
interface d_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_we;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport slave (
        input  req_valid, req_addr, req_size, req_we, req_signed, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_addr, req_size, req_we, req_signed, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/d_mem_lsu.sv
// Byte-enabled data memory with a one-request-at-a-time load/store FSM.
// An access that crosses a word boundary is split into two array beats.
module d_mem_lsu #(
    parameter  int MEM_SIZE_BYTES = 1024,
    localparam int MEM_SIZE_WORDS = MEM_SIZE_BYTES / 4,
    localparam int ADDR_W         = $clog2(MEM_SIZE_WORDS)
) (
    input  logic           clk,
    input  logic           rst,
    d_mem_lsu_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [1:0]          size_q, size_d;
    logic                we_q, we_d;
    logic                signed_q, signed_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         lo_word_q, lo_word_d;

    logic [31:0]         mem [MEM_SIZE_WORDS];
    logic [31:0]         mem_rdata_q;
    logic                mem_en;
    logic [3:0]          mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [31:0]         mem_wdata;

    logic [2:0]          req_nbytes;
    logic [32:0]         req_last_byte;
    logic                req_err;
    logic [3:0]          nmask;
    logic [7:0]          lane_mask;
    logic [63:0]         wdata_sh;
    logic                crossing;
    logic [ADDR_W-1:0]   word_idx;
    logic [4:0]          byte_sh;
    logic [31:0]         lo_word;
    logic [31:0]         window;
    logic [31:0]         load_raw;
    logic                ext_bit;
    logic [31:0]         load_ext;

    // Range check uses 33 bits so an access near 0xFFFFFFFF cannot wrap to 0.
    always_comb begin
        case (bus.req_size)
            2'b00:   req_nbytes = 3'd1;
            2'b01:   req_nbytes = 3'd2;
            2'b10:   req_nbytes = 3'd4;
            default: req_nbytes = 3'd0;
        endcase
        req_last_byte = {1'b0, bus.req_addr} + {30'b0, req_nbytes} - 33'd1;
        req_err       = (bus.req_size == 2'b11) || (req_last_byte >= 33'(MEM_SIZE_BYTES));
    end

    // Lane mask and store data are laid out over two words; the upper half feeds BEAT1.
    always_comb begin
        case (size_q)
            2'b00:   nmask = 4'b0001;
            2'b01:   nmask = 4'b0011;
            default: nmask = 4'b1111;
        endcase
        lane_mask = {4'b0000, nmask} << addr_q[1:0];
        wdata_sh  = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        crossing  = |lane_mask[7:4];
        word_idx  = addr_q[ADDR_W+1:2];
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        size_d    = size_q;
        we_d      = we_q;
        signed_d  = signed_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        lo_word_d = lo_word_q;
        mem_en    = 1'b0;
        mem_be    = 4'b0000;
        mem_addr  = word_idx;
        mem_wdata = wdata_sh[31:0];
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d   = bus.req_addr[ADDR_W+1:0];
                    size_d   = bus.req_size;
                    we_d     = bus.req_we;
                    signed_d = bus.req_signed;
                    wdata_d  = bus.req_wdata;
                    err_d    = req_err;
                    state_d  = req_err ? RESP : BEAT0;
                end
            end
            BEAT0: begin
                mem_en  = 1'b1;
                mem_be  = (we_q && !rst) ? lane_mask[3:0] : 4'b0000;
                state_d = crossing ? BEAT1 : RESP;
            end
            BEAT1: begin
                mem_en    = 1'b1;
                mem_addr  = word_idx + ADDR_W'(1);
                mem_wdata = wdata_sh[63:32];
                mem_be    = (we_q && !rst) ? lane_mask[7:4] : 4'b0000;
                lo_word_d = mem_rdata_q;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            size_q    <= 2'b00;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            lo_word_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            we_q      <= we_d;
            signed_q  <= signed_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            lo_word_q <= lo_word_d;
        end
    end

    // Array keeps no reset so it maps onto block RAM; read data is registered.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
            mem_rdata_q <= mem[mem_addr];
        end
    end

    // In RESP the read register holds the last beat; lo_word_q holds BEAT0 of a split load.
    always_comb begin
        byte_sh = {addr_q[1:0], 3'b000};
        lo_word = crossing ? lo_word_q : mem_rdata_q;
        window  = (lo_word >> byte_sh) | (mem_rdata_q << (6'd32 - {1'b0, byte_sh}));
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_load_lane
        assign load_raw[8*gi +: 8] = nmask[gi] ? window[8*gi +: 8] : 8'h00;
    end

    always_comb begin
        ext_bit  = 1'b0;
        load_ext = load_raw;
        case (size_q)
            2'b00: begin
                ext_bit  = signed_q & load_raw[7];
                load_ext = {{24{ext_bit}}, load_raw[7:0]};
            end
            2'b01: begin
                ext_bit  = signed_q & load_raw[15];
                load_ext = {{16{ext_bit}}, load_raw[15:0]};
            end
            default: load_ext = load_raw;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !err_q && !we_q) ? load_ext : 32'h0;

endmodule
